// File: rtl/prime_uart_reporter.sv
// rtl/prime_uart_reporter.sv - formats each accepted prime (or overflow) as hex ASCII + CR LF and sends it as UART 8N1
module prime_uart_reporter #(
    parameter int WIDTH_LOG    = 4,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [(1<<WIDTH_LOG)-1:0]   in_data,
    input  logic                        in_err,
    output logic                        tx,
    output logic                        busy,
    output logic [15:0]                 msg_count
);
    localparam int W       = 1 << WIDTH_LOG;
    localparam int N_HEX   = W / 4;
    localparam int N_CHARS = N_HEX + 2;
    localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit;
    logic [3:0]          r_idx;
    logic [7:0]          r_shift;
    logic [W-1:0]        r_data;
    logic                r_err;
    logic                r_tx;
    logic                r_busy;
    logic [15:0]         r_msg_count;

    logic                w_accept;
    logic                w_baud_end;
    logic                w_last_char;
    logic                w_tx_next;
    logic [3:0]          w_nib;
    logic [7:0]          w_hex;
    logic [7:0]          w_char;

    assign in_ready    = (r_state == S_IDLE) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_baud_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_last_char = (r_idx == (r_err ? 4'd4 : 4'(N_CHARS - 1)));
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign msg_count   = r_msg_count;

    // Character for the current index: hex digits MSB-first, then CR LF
    always_comb begin
        w_nib = 4'h0;
        for (int i = 0; i < N_HEX; i++) begin
            if (r_idx == 4'(i)) begin
                w_nib = r_data[W-1-4*i -: 4];
            end
        end
        w_hex = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
        if (r_err) begin
            case (r_idx)
                4'd0:       w_char = 8'h45;
                4'd1, 4'd2: w_char = 8'h52;
                4'd3:       w_char = 8'h0D;
                default:    w_char = 8'h0A;
            endcase
        end else if (r_idx < 4'(N_HEX)) begin
            w_char = w_hex;
        end else if (r_idx == 4'(N_HEX)) begin
            w_char = 8'h0D;
        end else begin
            w_char = 8'h0A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // tx is registered from the state, so the line lags the FSM by one cycle
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_end && (r_bit == 3'd7)) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_state_next = w_last_char ? S_DONE : S_START;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud      <= '0;
            r_bit       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_msg_count <= '0;
        end else begin
            r_tx <= w_tx_next;
            if ((r_state == S_IDLE) || (r_state == S_DONE) || w_baud_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data <= in_data;
                        r_err  <= in_err;
                        r_busy <= 1'b1;
                        r_idx  <= '0;
                        r_bit  <= '0;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_shift <= w_char;
                        r_bit   <= '0;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end && !w_last_char) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                S_DONE: begin
                    r_busy      <= 1'b0;
                    r_msg_count <= r_msg_count + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prime_uart_reporter.sv
// tb/tb_prime_uart_reporter.sv - scoreboard bench for prime_uart_reporter (16-bit/4 clk and 32-bit/2 clk instances)
module tb_prime_uart_reporter;
    localparam int CPB_A = 4;
    localparam int CPB_B = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, va, ea, rdy_a, tx_a, busy_a;
    logic [15:0] da, cnt_a;
    logic        rst_b, vb, eb, rdy_b, tx_b, busy_b;
    logic [31:0] db;
    logic [15:0] cnt_b;

    prime_uart_reporter #(.WIDTH_LOG(4), .CLKS_PER_BIT(CPB_A)) u_dut_a (
        .clk(clk), .rst(rst_a), .in_valid(va), .in_ready(rdy_a), .in_data(da),
        .in_err(ea), .tx(tx_a), .busy(busy_a), .msg_count(cnt_a)
    );

    prime_uart_reporter #(.WIDTH_LOG(5), .CLKS_PER_BIT(CPB_B)) u_dut_b (
        .clk(clk), .rst(rst_b), .in_valid(vb), .in_ready(rdy_b), .in_data(db),
        .in_err(eb), .tx(tx_b), .busy(busy_b), .msg_count(cnt_b)
    );

    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          exp_cnt[2] = '{0, 0};
    logic [7:0]  q_a[$];
    logic [7:0]  q_b[$];

    function automatic void check(string name, longint act, longint exp);
        chk_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    function automatic logic get_tx(int inst);   return (inst == 0) ? tx_a   : tx_b;   endfunction
    function automatic logic get_rst(int inst);  return (inst == 0) ? rst_a  : rst_b;  endfunction
    function automatic logic get_rdy(int inst);  return (inst == 0) ? rdy_a  : rdy_b;  endfunction
    function automatic logic get_busy(int inst); return (inst == 0) ? busy_a : busy_b; endfunction
    function automatic logic [15:0] get_cnt(int inst); return (inst == 0) ? cnt_a : cnt_b; endfunction
    function automatic int qsize(int inst); return (inst == 0) ? q_a.size() : q_b.size(); endfunction

    function automatic void push_q(int inst, logic [7:0] ch);
        if (inst == 0) q_a.push_back(ch);
        else           q_b.push_back(ch);
    endfunction

    // Reference: the ASCII text a host should see for one report
    function automatic void push_exp(int inst, longint d, bit err);
        int nhex = (inst == 0) ? 4 : 8;
        int nib;
        if (err) begin
            push_q(inst, 8'h45); push_q(inst, 8'h52); push_q(inst, 8'h52);
        end else begin
            for (int i = 0; i < nhex; i++) begin
                nib = int'((d >> (4 * (nhex - 1 - i))) & 15);
                push_q(inst, (nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
            end
        end
        push_q(inst, 8'h0D);
        push_q(inst, 8'h0A);
    endfunction

    task automatic drive(int inst, bit v, longint d, bit e);
        if (inst == 0) begin va = v; da = d[15:0]; ea = e; end
        else           begin vb = v; db = d[31:0]; eb = e; end
    endtask

    // UART receiver: every bit sampled on each negedge must hold for exactly cpb samples
    task automatic mon(input int inst, input int cpb);
        logic [9:0] val;
        logic [7:0] exp_b;
        logic       v;
        bit         abort, wok;
        forever begin
            @(negedge clk);
            if (get_rst(inst) || (get_tx(inst) !== 1'b0)) continue;
            val = '0; abort = 0; wok = 1;
            for (int b = 0; b < 10 && !abort; b++) begin
                for (int s = 0; s < cpb && !abort; s++) begin
                    if (b != 0 || s != 0) @(negedge clk);
                    if (get_rst(inst)) abort = 1;
                    else begin
                        v = get_tx(inst);
                        if (s == 0) val[b] = v;
                        else if (v !== val[b]) wok = 0;
                    end
                end
            end
            if (!abort) begin
                check($sformatf("bit_width_%0d", inst), wok, 1);
                check($sformatf("stop_bit_%0d", inst), val[9], 1);
                check($sformatf("char_expected_%0d", inst), qsize(inst) > 0, 1);
                if (qsize(inst) > 0) begin
                    exp_b = (inst == 0) ? q_a.pop_front() : q_b.pop_front();
                    check($sformatf("char_%0d", inst), val[8:1], exp_b);
                end
            end
        end
    endtask

    initial mon(0, CPB_A);
    initial mon(1, CPB_B);

    task automatic wait_ready(int inst);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!get_rdy(inst) && n < 3000);
        if (!get_rdy(inst)) check("ready_timeout", 0, 1);
    endtask

    task automatic accept_msg(int inst, longint d, bit e);
        wait_ready(inst);
        drive(inst, 1'b1, d, e);
        push_exp(inst, d, e);
        @(posedge clk); #1;
        drive(inst, 1'b0, longint'($urandom), 1'($urandom_range(0, 1)));
        @(negedge clk);
        check("tx_high_at_accept", get_tx(inst), 1);
        check("busy_after_accept", get_busy(inst), 1);
        check("ready_after_accept", get_rdy(inst), 0);
    endtask

    task automatic finish_msg(int inst, int nchars, int cpb);
        int n = 1;
        int first0 = -1;
        while (n < 5000) begin
            @(negedge clk);
            n++;
            if (get_tx(inst) === 1'b0 && first0 < 0) first0 = n;
            if (get_rdy(inst)) break;
        end
        exp_cnt[inst]++;
        check("start_latency", first0, 2);
        check("msg_cycles", n, nchars * 10 * cpb + 2);
        check("msg_count", get_cnt(inst), exp_cnt[inst] & 16'hFFFF);
        check("busy_cleared", get_busy(inst), 0);
    endtask

    task automatic send(int inst, longint d, bit e);
        accept_msg(inst, d, e);
        finish_msg(inst, e ? 5 : ((inst == 0) ? 6 : 10), (inst == 0) ? CPB_A : CPB_B);
    endtask

    task automatic back_to_back();
        int     queued = 0, done = 0, run = 0, cyc = 0, n = 0;
        bit     pend = 0, will;
        logic   t, prev = 1'b1;
        longint d;
        wait_ready(0);
        while ((queued < 3 || pend) && cyc < 3000) begin
            will = 0;
            if (queued < 3) begin
                d = longint'($urandom_range(0, 65535));
                drive(0, 1'b1, d, 1'b0);
                will = rdy_a;
                if (will) begin push_exp(0, d, 1'b0); queued++; end
            end else begin
                drive(0, 1'b0, 0, 1'b0);
            end
            @(negedge clk);
            t = tx_a;
            if (t === 1'b0 && prev === 1'b1 && pend) begin
                if (done > 1) check("b2b_gap", run, CPB_A + 2);
                pend = 0;
            end
            run  = (t === 1'b1) ? run + 1 : 0;
            prev = t;
            @(posedge clk);
            if (will) begin pend = 1; done++; end
            #1;
            cyc++;
        end
        drive(0, 1'b0, 0, 1'b0);
        check("b2b_accepts", done, 3);
        while (!rdy_a && n < 3000) begin @(negedge clk); n++; end
        exp_cnt[0] += 3;
        check("b2b_msg_count", cnt_a, exp_cnt[0]);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        drive(0, 1'b0, 0, 1'b0);
        drive(1, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_a", tx_a, 1);     check("rst_tx_b", tx_b, 1);
        check("rst_busy_a", busy_a, 0); check("rst_busy_b", busy_b, 0);
        check("rst_cnt_a", cnt_a, 0);   check("rst_cnt_b", cnt_b, 0);
        check("rst_rdy_a", rdy_a, 0);   check("rst_rdy_b", rdy_b, 0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;

        send(0, 16'h0007, 1'b0);
        send(0, 16'hFFFB, 1'b0);
        send(0, 16'h1234, 1'b1);
        send(0, 16'h0000, 1'b0);
        send(0, 16'hFFFF, 1'b0);
        repeat (5) send(0, longint'($urandom_range(0, 65535)), ($urandom_range(0, 3) == 0));

        back_to_back();

        accept_msg(0, longint'($urandom_range(0, 65535)), 1'b0);
        repeat (23 * CPB_A) @(posedge clk);
        #1 rst_a = 1'b1;
        @(negedge clk);
        check("rdy_during_rst", rdy_a, 0);
        @(posedge clk); #1;
        rst_a = 1'b0;
        q_a.delete();
        exp_cnt[0] = 0;
        @(negedge clk);
        check("midrst_tx", tx_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_cnt", cnt_a, 0);
        send(0, longint'($urandom_range(0, 65535)), 1'b0);

        send(1, 32'h0001000F, 1'b0);
        send(1, longint'($urandom), 1'b0);
        send(1, longint'($urandom), 1'b1);

        repeat (20) @(negedge clk);
        check("leftover_a", q_a.size(), 0);
        check("leftover_b", q_b.size(), 0);
        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
